// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline family.
//   PIPE_DEF_WIDTH / PIPE_DEF_DEPTH : default payload width and stage count.
//   cnt_w(n)                        : width of an occupancy counter able to hold
//                                     0..n, never narrower than one bit.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_DEF_WIDTH = 32;
    localparam int PIPE_DEF_DEPTH = 2;

    // Counter width for values 0..n; a zero-stage pipe still gets a 1-bit port.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            cnt_w = 1;
        end else begin
            cnt_w = w;
        end
    endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// -----------------------------------------------------------------------------
// pipe_elastic_stage
// One valid/data register pair of the elastic pipeline.
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset (clears valid, optionally data)
//   flush_i  : clear valid; data holds
//   load_i   : stage may take a new value this cycle (ready chain term)
//   valid_i  : valid bit offered by the upstream stage / input handshake
//   data_i   : payload offered by the upstream stage / input
//   valid_o  : registered valid bit
//   data_o   : registered payload
// -----------------------------------------------------------------------------
module pipe_elastic_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = PIPE_DEF_WIDTH,
    parameter int               RESET_DATA = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             data_we_s;

    // Payload only moves with a valid entry; reset and flush freeze it so the
    // previous contents survive when the data flops have no reset.
    assign data_we_s = reset & load_i & valid_i & ~flush_i;

    // Next-state valid: flush empties the stage, a load copies the upstream bit.
    always_comb begin
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Next-state payload: take the upstream value on a write, else hold.
    always_comb begin
        if (data_we_s) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Valid register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    generate
        if (RESET_DATA != 0) begin : g_data_rst
            // Payload register cleared to RESET_VAL by reset.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_q <= RESET_VAL;
                end else begin
                    data_q <= data_d;
                end
            end
        end else begin : g_data_norst
            // Payload register without a reset term (plain enable flop / SRL).
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end
    endgenerate

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_elastic.sv
// -----------------------------------------------------------------------------
// pipe_elastic
// WIDTH-bit, N-stage elastic pipeline with per-stage valid bits, ready/valid
// backpressure, bubble collapsing, flush and a registered occupancy count.
// With no stalls and no flush it is an exact N-cycle delay line; N=0 is a
// combinational pass-through.
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   i_flush    : discard all in-flight entries
//   i_valid    : upstream entry present
//   i_data     : upstream payload
//   o_ready_up : pipeline accepts an entry this cycle (may depend on i_ready_dn)
//   o_valid    : last stage holds a valid entry
//   o_data     : payload of the last stage
//   i_ready_dn : downstream accepts the entry this cycle
//   o_count    : number of valid stages
// -----------------------------------------------------------------------------
module pipe_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = PIPE_DEF_WIDTH,
    parameter int               N          = PIPE_DEF_DEPTH,
    parameter int               RESET_DATA = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [WIDTH-1:0]    i_data,
    output logic                o_ready_up,
    output logic                o_valid,
    output logic [WIDTH-1:0]    o_data,
    input  logic                i_ready_dn,
    output logic [cnt_w(N)-1:0] o_count
);

    localparam int CW = cnt_w(N);

    generate
        if (N == 0) begin : g_pass
            // No storage: the handshake passes straight through.
            logic unused_clk_s;

            assign unused_clk_s = clk;
            assign o_valid      = i_valid;
            assign o_data       = i_data;
            assign o_ready_up   = i_ready_dn & ~i_flush & reset;
            assign o_count      = {CW{1'b0}};
        end else begin : g_pipe
            logic [N-1:0]     v_s;
            logic [WIDTH-1:0] d_s [N];
            logic [N-1:0]     rdy_s;
            logic             in_fire_s;
            logic             out_fire_s;
            logic [CW-1:0]    count_q;
            logic [CW-1:0]    count_d;

            // Ready chain, evaluated from the output end back to stage 0: a
            // stage can load if it is empty or its successor can load, which
            // is what lets bubbles collapse behind a stalled output.
            always_comb begin
                rdy_s = {N{1'b0}};
                rdy_s[N-1] = ~v_s[N-1] | i_ready_dn;
                for (int k = N - 2; k >= 0; k--) begin
                    rdy_s[k] = ~v_s[k] | rdy_s[k+1];
                end
            end

            assign o_ready_up = rdy_s[0] & ~i_flush & reset;
            assign in_fire_s  = i_valid & o_ready_up;
            assign out_fire_s = v_s[N-1] & i_ready_dn;

            for (genvar k = 0; k < N; k++) begin : g_stage
                logic             v_in_s;
                logic [WIDTH-1:0] d_in_s;

                if (k == 0) begin : g_head
                    assign v_in_s = in_fire_s;
                    assign d_in_s = i_data;
                end else begin : g_body
                    assign v_in_s = v_s[k-1];
                    assign d_in_s = d_s[k-1];
                end

                pipe_elastic_stage #(
                    .WIDTH      (WIDTH),
                    .RESET_DATA (RESET_DATA),
                    .RESET_VAL  (RESET_VAL)
                ) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .flush_i (i_flush),
                    .load_i  (rdy_s[k]),
                    .valid_i (v_in_s),
                    .data_i  (d_in_s),
                    .valid_o (v_s[k]),
                    .data_o  (d_s[k])
                );
            end

            // Occupancy next state; a simultaneous in and out fire cancels.
            always_comb begin
                if (i_flush) begin
                    count_d = {CW{1'b0}};
                end else begin
                    count_d = count_q + CW'(in_fire_s) - CW'(out_fire_s);
                end
            end

            // Occupancy register with synchronous active-low reset.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    count_q <= {CW{1'b0}};
                end else begin
                    count_q <= count_d;
                end
            end

            assign o_valid = v_s[N-1];
            assign o_data  = d_s[N-1];
            assign o_count = count_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_elastic
// Directed bench for pipe_elastic. Four instances share clock and reset:
//   u3 : N=3, RESET_DATA=1, RESET_VAL=0x5A (streaming, backpressure, reset)
//   u2 : N=2, RESET_DATA=0                 (full with simultaneous fire, reset)
//   u4 : N=4                               (flush)
//   u0 : N=0                               (pass-through)
// Accepted entries are queued per instance and compared in order on each
// output transfer; o_count is compared with the queue length every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_elastic;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       vi3 = 1'b0, rdn3 = 1'b1, fl3 = 1'b0, ru3, vo3;
    logic [7:0] di3 = 8'h00, do3;
    logic [1:0] c3;
    logic       vi2 = 1'b0, rdn2 = 1'b1, fl2 = 1'b0, ru2, vo2;
    logic [7:0] di2 = 8'h00, do2;
    logic [1:0] c2;
    logic       vi4 = 1'b0, rdn4 = 1'b1, fl4 = 1'b0, ru4, vo4;
    logic [7:0] di4 = 8'h00, do4;
    logic [2:0] c4;
    logic       vi0 = 1'b0, rdn0 = 1'b1, fl0 = 1'b0, ru0, vo0;
    logic [7:0] di0 = 8'h00, do0;
    logic [0:0] c0;

    logic [7:0] q3[$];
    logic [7:0] q2[$];
    logic [7:0] q4[$];

    int n_pass  = 0;
    int n_total = 0;

    pipe_elastic #(.WIDTH(8), .N(3), .RESET_DATA(1), .RESET_VAL(8'h5A)) u3 (
        .clk(clk), .reset(rst_n), .i_flush(fl3), .i_valid(vi3), .i_data(di3),
        .o_ready_up(ru3), .o_valid(vo3), .o_data(do3), .i_ready_dn(rdn3), .o_count(c3));

    pipe_elastic #(.WIDTH(8), .N(2), .RESET_DATA(0), .RESET_VAL(8'h00)) u2 (
        .clk(clk), .reset(rst_n), .i_flush(fl2), .i_valid(vi2), .i_data(di2),
        .o_ready_up(ru2), .o_valid(vo2), .o_data(do2), .i_ready_dn(rdn2), .o_count(c2));

    pipe_elastic #(.WIDTH(8), .N(4), .RESET_DATA(0), .RESET_VAL(8'h00)) u4 (
        .clk(clk), .reset(rst_n), .i_flush(fl4), .i_valid(vi4), .i_data(di4),
        .o_ready_up(ru4), .o_valid(vo4), .o_data(do4), .i_ready_dn(rdn4), .o_count(c4));

    pipe_elastic #(.WIDTH(8), .N(0), .RESET_DATA(0), .RESET_VAL(8'h00)) u0 (
        .clk(clk), .reset(rst_n), .i_flush(fl0), .i_valid(vi0), .i_data(di0),
        .o_ready_up(ru0), .o_valid(vo0), .o_data(do0), .i_ready_dn(rdn0), .o_count(c0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: inputs are already driven (after a falling edge).
    // Scoreboard the handshakes, cross the rising edge, end on the falling edge.
    task automatic cyc();
        logic [7:0] e;
        #1;
        if (rst_n) begin
            chk("cnt3", 32'(c3), 32'(q3.size()));
            if (vo3 && rdn3) begin
                chk("nonempty3", 32'(q3.size() != 0), 32'd1);
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    chk("data3", 32'(do3), 32'(e));
                end
            end
            if (vi3 && ru3) q3.push_back(di3);

            chk("cnt2", 32'(c2), 32'(q2.size()));
            if (vo2 && rdn2) begin
                chk("nonempty2", 32'(q2.size() != 0), 32'd1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    chk("data2", 32'(do2), 32'(e));
                end
            end
            if (vi2 && ru2) q2.push_back(di2);

            chk("cnt4", 32'(c4), 32'(q4.size()));
            if (vo4 && rdn4) begin
                chk("nonempty4", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("data4", 32'(do4), 32'(e));
                end
            end
            if (vi4 && ru4) q4.push_back(di4);
        end
        @(posedge clk);
        if (!rst_n) begin
            q3.delete();
            q2.delete();
            q4.delete();
        end else begin
            if (fl3) q3.delete();
            if (fl2) q2.delete();
            if (fl4) q4.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_bp [3];
        logic [7:0] p0_d   [4];
        logic       p0_v   [4];
        logic       p0_r   [4];
        logic       p0_f   [4];
        exp_bp = '{8'hA5, 8'hB6, 8'hC7};
        p0_d   = '{8'h3C, 8'hC3, 8'h99, 8'h0F};
        p0_v   = '{1'b1, 1'b0, 1'b1, 1'b0};
        p0_r   = '{1'b1, 1'b0, 1'b1, 1'b1};
        p0_f   = '{1'b0, 1'b0, 1'b1, 1'b0};

        // ---- reset ----
        @(negedge clk);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_vld3", 32'(vo3), 32'd0);
        chk("rst_cnt3", 32'(c3), 32'd0);
        chk("rst_rdy3", 32'(ru3), 32'd1);
        chk("rst_dat3", 32'(do3), 32'h5A);
        chk("rst_cnt2", 32'(c2), 32'd0);
        chk("rst_rdy4", 32'(ru4), 32'd1);

        // ---- streaming, N=3: accepted at t, visible at t+3 ----
        for (int t = 0; t < 8; t++) begin
            vi3  = (t < 4);
            di3  = (t < 4) ? 8'(8'h11 * (t + 1)) : 8'h00;
            rdn3 = 1'b1;
            #1;
            chk("stream_rdy", 32'(ru3), 32'd1);
            chk("stream_vld", 32'(vo3), 32'(t >= 3 && t <= 6));
            if (t >= 3 && t <= 6) chk("stream_dat", 32'(do3), 32'(8'h11 * (t - 2)));
            cyc();
        end

        // ---- backpressure / bubble collapse, N=3 ----
        rdn3 = 1'b0; vi3 = 1'b1; di3 = 8'hA5;
        #1; chk("bp_rdy0", 32'(ru3), 32'd1);
        cyc();
        vi3 = 1'b0;
        cyc();
        cyc();
        vi3 = 1'b1; di3 = 8'hB6;
        #1;
        chk("bp_head_vld", 32'(vo3), 32'd1);
        chk("bp_head_dat", 32'(do3), 32'hA5);
        chk("bp_rdy1", 32'(ru3), 32'd1);
        cyc();
        di3 = 8'hC7;
        #1; chk("bp_rdy2", 32'(ru3), 32'd1);
        cyc();
        di3 = 8'hD8;
        #1;
        chk("bp_full_rdy", 32'(ru3), 32'd0);
        chk("bp_full_cnt", 32'(c3), 32'd3);
        chk("bp_full_dat", 32'(do3), 32'hA5);
        cyc();
        vi3 = 1'b0;
        #1; chk("bp_hold_dat", 32'(do3), 32'hA5);
        cyc();
        rdn3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rel_vld", 32'(vo3), 32'(i < 3));
            if (i < 3) chk("bp_rel_dat", 32'(do3), 32'(exp_bp[i]));
            cyc();
        end

        // ---- full with simultaneous fire, N=2 ----
        rdn2 = 1'b0; vi2 = 1'b1; di2 = 8'h31;
        cyc();
        di2 = 8'h32;
        cyc();
        rdn2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            di2 = 8'(8'h33 + i);
            #1;
            chk("full_rdy", 32'(ru2), 32'd1);
            chk("full_cnt", 32'(c2), 32'd2);
            chk("full_dat", 32'(do2), 32'(8'h31 + i));
            cyc();
        end
        vi2 = 1'b0;
        cyc();
        cyc();
        #1;
        chk("full_drain_vld", 32'(vo2), 32'd0);
        chk("full_drain_cnt", 32'(c2), 32'd0);

        // ---- flush, N=4 holding three entries ----
        rdn4 = 1'b0; vi4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            di4 = 8'(8'h41 + i);
            cyc();
        end
        fl4 = 1'b1; di4 = 8'hEE;
        #1;
        chk("flush_rdy", 32'(ru4), 32'd0);
        chk("flush_cnt", 32'(c4), 32'd3);
        cyc();
        fl4 = 1'b0; vi4 = 1'b0; rdn4 = 1'b1;
        #1;
        chk("flush_vld", 32'(vo4), 32'd0);
        chk("flush_cnt0", 32'(c4), 32'd0);
        chk("flush_rdy_after", 32'(ru4), 32'd1);
        for (int i = 0; i < 5; i++) begin
            #1; chk("flush_no_ghost", 32'(vo4), 32'd0);
            cyc();
        end

        // ---- N=0 pass-through ----
        for (int i = 0; i < 4; i++) begin
            vi0 = p0_v[i]; di0 = p0_d[i]; rdn0 = p0_r[i]; fl0 = p0_f[i];
            #1;
            chk("p0_vld", 32'(vo0), 32'(p0_v[i]));
            chk("p0_dat", 32'(do0), 32'(p0_d[i]));
            chk("p0_rdy", 32'(ru0), 32'(p0_r[i] & ~p0_f[i]));
            chk("p0_cnt", 32'(c0), 32'd0);
            cyc();
        end
        fl0 = 1'b0; rdn0 = 1'b1;

        // ---- reset mid-stream ----
        vi3 = 1'b1; rdn3 = 1'b1; di3 = 8'h61;
        vi2 = 1'b1; rdn2 = 1'b0; di2 = 8'h71;
        cyc();
        di3 = 8'h62; di2 = 8'h72;
        cyc();
        di3 = 8'h63; di2 = 8'h73;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy3", 32'(ru3), 32'd0);
        chk("rst_mid_rdy2", 32'(ru2), 32'd0);
        chk("rst_mid_rdy0", 32'(ru0), 32'd0);
        chk("rst_mid_pre2", 32'(do2), 32'h71);
        cyc();
        rst_n = 1'b1;
        vi3 = 1'b0; vi2 = 1'b0; rdn2 = 1'b1;
        #1;
        chk("rst_after_vld3", 32'(vo3), 32'd0);
        chk("rst_after_cnt3", 32'(c3), 32'd0);
        chk("rst_after_dat3", 32'(do3), 32'h5A);
        chk("rst_after_vld2", 32'(vo2), 32'd0);
        chk("rst_after_cnt2", 32'(c2), 32'd0);
        chk("rst_after_dat2", 32'(do2), 32'h71);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
